// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the iterative carry-save multiplier (csa_mul_seq).
//   - WIDTH_DEF : default operand width (product is 2*WIDTH_DEF)
//   - state_t   : sequencer states
//   - maj3      : 3-input majority, the carry function of a full adder
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITER    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : mul_pkg

// File: rtl/csa_row.sv
// ---------------------------------------------------------------------------
// csa1bit
//   One carry-save cell: compresses three bits into a sum bit and a carry
//   bit of the next higher weight.
//   Ports: x, y, z (in) ; cout, sum (out)
//
// csa_row
//   N parallel csa1bit cells. Purely combinational: the caller owns all state
//   and is responsible for shifting cout left by one before reuse.
//   Ports: x, y, z [N-1:0] (in) ; cout, sum [N-1:0] (out)
// ---------------------------------------------------------------------------
module csa1bit
  import mul_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic z,
  output logic cout,
  output logic sum
);

  assign sum  = x ^ y ^ z;
  assign cout = maj3(x, y, z);

endmodule : csa1bit

module csa_row #(
  parameter int N = 2 * mul_pkg::WIDTH_DEF
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] cout,
  output logic [N-1:0] sum
);

  for (genvar i = 0; i < N; i++) begin : g_cell
    csa1bit u_cell (
      .x    (x[i]),
      .y    (y[i]),
      .z    (z[i]),
      .cout (cout[i]),
      .sum  (sum[i])
    );
  end

endmodule : csa_row

// File: rtl/csa_mul_seq.sv
// ---------------------------------------------------------------------------
// csa_mul_seq
//   Iterative multiply sequencer for MULT / MULTU. Operands are converted to
//   magnitudes, one partial product per cycle is folded into a 2*WIDTH
//   carry-save accumulator (sum/carry), a single carry-propagate add resolves
//   the accumulator, and the sign is reapplied before {hi,lo} is registered.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     start      request, sampled only in IDLE
//     is_signed  1 = MULT, 0 = MULTU (latched with start)
//     op_a       multiplicand (latched with start)
//     op_b       multiplier   (latched with start)
//     abort      pipeline flush; cancels an operation in ITER / RESOLVE
//     busy       high in ITER and RESOLVE
//     done       one-cycle pulse, hi/lo valid
//     hi, lo     upper / lower product word
//
//   Build option:
//     MUL_EARLY_TERM_EN  when defined, ITER exits to RESOLVE as soon as no
//                        multiplier bit at or above the current index is set.
//                        Undefined: fixed WIDTH+1 cycle latency.
// ---------------------------------------------------------------------------
module csa_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [PW-1:0]    sum_q;
  logic [PW-1:0]    carry_q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             mplier_bit;
  logic             last_iter;
  logic             rest_zero;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    row_sum, row_cout;
  logic [PW-1:0]    prod_mag, prod;

  // -------------------------------------------------------------------------
  // Operand magnitudes. For the most negative value the two's-complement
  // negation wraps back to itself, which read as unsigned is the correct
  // magnitude (2^(WIDTH-1)), so no extra bit is needed.
  // -------------------------------------------------------------------------
  assign mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // -------------------------------------------------------------------------
  // Partial product for the current iteration and the carry-save row.
  // -------------------------------------------------------------------------
  assign mplier_bit = mplier[cnt[CNT_W-2:0]];
  assign pp         = mplier_bit ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
  assign last_iter  = (cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_TERM_EN
  // Nothing left to accumulate once every remaining multiplier bit is zero.
  // Leaving now is exact: the accumulator already holds the full product.
  assign rest_zero = ((mplier >> cnt) == '0);
`else
  assign rest_zero = 1'b0;
`endif

  csa_row #(.N(PW)) u_row (
    .x    (sum_q),
    .y    (carry_q),
    .z    (pp),
    .cout (row_cout),
    .sum  (row_sum)
  );

  // Single carry-propagate add, then reapply the sign (mod 2^PW).
  assign prod_mag = sum_q + carry_q;
  assign prod     = neg ? -prod_mag : prod_mag;

  // -------------------------------------------------------------------------
  // FSM: state register.
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would create
  // order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. Abort outranks everything in ITER / RESOLVE and
  // also blocks a same-cycle start in IDLE.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; a missing branch
    // would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = ITER;
      end
      ITER: begin
        if (abort)                       state_nxt = IDLE;
        else if (last_iter || rest_zero) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (abort) state_nxt = IDLE;
        else       state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers. Operand/accumulator state is only meaningful between
  // a start and the following RESOLVE; an abort simply abandons it and the
  // next start reinitialises everything.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            mcand   <= mag_a;
            mplier  <= mag_b;
            neg     <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            sum_q   <= '0;
            carry_q <= '0;
            cnt     <= '0;
          end
        end
        ITER: begin
          sum_q   <= row_sum;
          // Carries carry the next higher weight; the top one falls off,
          // which is harmless because the true product fits in PW bits.
          carry_q <= {row_cout[PW-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
        end
        RESOLVE: begin
          if (!abort) {hi, lo} <= prod;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ITER) || (state == RESOLVE);
  assign done = (state == DONE);

endmodule : csa_mul_seq

// File: tb/tb_csa_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_csa_mul_seq
//   Self-checking bench for csa_mul_seq (WIDTH=32). Expected products come
//   from plain 64-bit arithmetic; expected latency comes from the operand's
//   highest set multiplier bit when MUL_EARLY_TERM_EN is defined, otherwise
//   the fixed WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module tb_csa_mul_seq;

  localparam int W = 32;
  localparam int MAX_WAIT = 60;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;

  csa_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; all sampling and driving happens here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product from ordinary integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic s);
    longint sa, sb;
    if (s) begin
      sa = {{32{a[W-1]}}, a};
      sb = {{32{b[W-1]}}, b};
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Cycles from the start edge to the first cycle with done high.
  function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef MUL_EARLY_TERM_EN
    logic [W-1:0] mag;
    int top, lat;
    mag = (s && b[W-1]) ? -b : b;
    top = -1;
    for (int i = 0; i < W; i++) if (mag[i]) top = i;
    lat = top + 3;
    if (lat > W + 1) lat = W + 1;
    return lat;
`else
    if (s) return W + 1;
    return W + 1;
`endif
  endfunction

  // Drive one operation and measure it; comparisons are made by the callers.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, output logic [63:0] got,
                       output int cyc, output logic busy0,
                       output logic busy_done, output logic done_after);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    tick();
    start = 1'b0;
    busy0 = busy;
    cyc = 0;
    while (done !== 1'b1 && cyc < MAX_WAIT) begin
      tick();
      cyc++;
    end
    got       = {hi, lo};
    busy_done = busy;
    tick();
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (hi !== '0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== '0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0]  ta [8];
    logic [W-1:0]  tb [8];
    logic          ts [8];
    logic [63:0]   te [8];
    logic [63:0]   got;
    int            cyc;
    logic          b0, bd, da;
    ta[0] = 32'hFFFFFFFF; tb[0] = 32'hFFFFFFFF; ts[0] = 0; te[0] = 64'hFFFFFFFE_00000001;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'h00000001; ts[1] = 1; te[1] = 64'hFFFFFFFF_FFFFFFFF;
    ta[2] = 32'h80000000; tb[2] = 32'h80000000; ts[2] = 1; te[2] = 64'h40000000_00000000;
    ta[3] = 32'h00000007; tb[3] = 32'hFFFFFFFD; ts[3] = 1; te[3] = 64'hFFFFFFFF_FFFFFFEB;
    ta[4] = 32'h00000007; tb[4] = 32'hFFFFFFFD; ts[4] = 0; te[4] = 64'h00000006_FFFFFFEB;
    ta[5] = 32'h12345678; tb[5] = 32'h00000003; ts[5] = 0; te[5] = 64'h00000000_369D0368;
    ta[6] = 32'hDEADBEEF; tb[6] = 32'h00000000; ts[6] = 1; te[6] = 64'h0;
    ta[7] = 32'h80000000; tb[7] = 32'h00000001; ts[7] = 1; te[7] = 64'hFFFFFFFF_80000000;
    for (int i = 0; i < 8; i++) begin
      do_op(ta[i], tb[i], ts[i], got, cyc, b0, bd, da);
      total++; if (b0 !== 1'b1) begin bad++; $display("FAIL dir%0d_busy_start: got %b want 1", i, b0); end
      total++; if (cyc != exp_lat(tb[i], ts[i])) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, exp_lat(tb[i], ts[i])); end
      total++; if (got !== te[i]) begin bad++; $display("FAIL dir%0d_product: got %h want %h", i, got, te[i]); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL dir%0d_busy_in_done: got %b want 0", i, bd); end
      total++; if (da !== 1'b0) begin bad++; $display("FAIL dir%0d_done_width: got %b want 0", i, da); end
    end
  endtask

  task automatic test_abort();
    logic [63:0] got, want;
    int          cyc, pulses;
    logic        b0, bd, da;
    logic [W-1:0] a, b;
    do_op(32'h7, 32'hFFFFFFFD, 1'b1, got, cyc, b0, bd, da);
    total++; if (got !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL abort_preload: got %h want %h", got, 64'hFFFFFFFF_FFFFFFEB); end
    // Abort in the middle of ITER (multiplier MSB set keeps it iterating).
    op_a = $urandom; op_b = $urandom | 32'h80000000; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL abort_hilo_kept: got %h want %h", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB); end
    // Abort beats a same-cycle start.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_priority: got busy %b want 0", busy); end
    // A fresh operation right afterwards completes normally.
    a = $urandom; b = $urandom;
    want = ref_prod(a, b, 1'b1);
    do_op(a, b, 1'b1, got, cyc, b0, bd, da);
    total++; if (got !== want) begin bad++; $display("FAIL abort_restart_product: got %h want %h", got, want); end
    total++; if (cyc != exp_lat(b, 1'b1)) begin bad++; $display("FAIL abort_restart_latency: got %0d want %0d", cyc, exp_lat(b, 1'b1)); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    int          cyc, pulses;
    logic        b0, bd, da;
    do_op(32'd5, 32'd6, 1'b0, got, cyc, b0, bd, da);
    total++; if (got !== 64'd30) begin bad++; $display("FAIL rstmid_preload: got %h want %h", got, 64'd30); end
    op_a = $urandom; op_b = $urandom | 32'h80000000; is_signed = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL rstmid_hilo: got %h want 0", {hi, lo}); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_held_start();
    logic [W-1:0] a, b;
    logic [63:0]  got, want;
    int           cyc, pulses;
    a = $urandom; b = $urandom;
    want = ref_prod(a, b, 1'b1);
    op_a = a; op_b = b; is_signed = 1'b1; start = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_busy: got %b want 1", busy); end
    cyc = 0;
    while (done !== 1'b1 && cyc < MAX_WAIT) begin
      tick();
      cyc++;
    end
    pulses = (done === 1'b1) ? 1 : 0;
    got = {hi, lo};
    // start is still high across the DONE edge and must not relaunch.
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_relaunch: got busy %b want 0", busy); end
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL held_pulses: got %0d want 1", pulses); end
    total++; if (got !== want) begin bad++; $display("FAIL held_product: got %h want %h", got, want); end
    total++; if (cyc != exp_lat(b, 1'b1)) begin bad++; $display("FAIL held_latency: got %0d want %0d", cyc, exp_lat(b, 1'b1)); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         s;
    logic [63:0]  got, want;
    int           cyc, sel;
    logic         b0, bd, da;
    for (int n = 0; n < 500; n++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      case (sel)
        0: a = 32'h80000000;
        1: b = 32'h80000000;
        2: b = 32'($urandom_range(0, 15));
        3: a = 32'hFFFFFFFF;
        default: ;
      endcase
      want = ref_prod(a, b, s);
      do_op(a, b, s, got, cyc, b0, bd, da);
      total++; if (got !== want) begin bad++; $display("FAIL rnd%0d_product a=%h b=%h s=%b: got %h want %h", n, a, b, s, got, want); end
      total++; if (cyc != exp_lat(b, s)) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, cyc, exp_lat(b, s)); end
      total++; if (da !== 1'b0) begin bad++; $display("FAIL rnd%0d_done_width: got %b want 0", n, da); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid();
    test_held_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_csa_mul_seq
